// File: rtl/display_controller.sv
// Captures a value from one of four sources on a display request and scans it
// as four hex digits onto a multiplexed, active-low seven-segment display.
module display_controller #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        display,
  input  logic [1:0]  disp_sel,
  input  logic [15:0] acc_data,
  input  logic [15:0] reg_data,
  input  logic [15:0] mem_data,
  input  logic        bool_flag,
  output logic        busy,
  output logic        disp_done,
  output logic [15:0] shown_value,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic          scan_on;
  logic [15:0]   sel_value;
  logic [3:0]    nibble;

  always_comb begin
    sel_value = acc_data;
    case (disp_sel)
      2'b00:   sel_value = acc_data;
      2'b01:   sel_value = reg_data;
      2'b11:   sel_value = {15'b0, bool_flag};
      default: sel_value = acc_data;
    endcase
  end

  // scan_on marks "something has been shown since reset"; it keeps the old
  // value scanning through a MEM_WAIT entered from SHOW, and stays low in a
  // MEM_WAIT entered from IDLE so the display remains blank there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shown_value <= '0;
      disp_done   <= 1'b0;
      scan_on     <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else begin
      disp_done <= 1'b0;
      if (scan_on) begin
        if (refresh_cnt == CNT_MAX) begin
          refresh_cnt <= '0;
          digit_idx   <= digit_idx + 2'd1;
        end else begin
          refresh_cnt <= refresh_cnt + CW'(1);
        end
      end
      case (state)
        IDLE, SHOW: begin
          if (display) begin
            if (disp_sel == 2'b10) begin
              state <= MEM_WAIT;
            end else begin
              shown_value <= sel_value;
              state       <= SHOW;
              scan_on     <= 1'b1;
              disp_done   <= 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          shown_value <= mem_data;
          state       <= SHOW;
          scan_on     <= 1'b1;
          disp_done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == MEM_WAIT);

  always_comb begin
    nibble = shown_value[3:0];
    case (digit_idx)
      2'd0: nibble = shown_value[3:0];
      2'd1: nibble = shown_value[7:4];
      2'd2: nibble = shown_value[11:8];
      2'd3: nibble = shown_value[15:12];
      default: nibble = shown_value[3:0];
    endcase
  end

  always_comb begin
    an  = '1;
    seg = '1;
    if (scan_on) begin
      an = ~(4'b0001 << digit_idx);
      case (nibble)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = '1;
      endcase
    end
  end

endmodule

// File: tb/tb_display_controller.sv
// Bench for display_controller with REFRESH_DIV=4: directed vector table,
// hand-written scan sequences, and random traffic against a behavioural model.
module tb_display_controller;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n, display, bool_flag;
  logic [1:0]  disp_sel;
  logic [15:0] acc_data, reg_data, mem_data;
  logic        busy, disp_done;
  logic [15:0] shown_value;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  display_controller #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .display(display), .disp_sel(disp_sel),
    .acc_data(acc_data), .reg_data(reg_data), .mem_data(mem_data),
    .bool_flag(bool_flag), .busy(busy), .disp_done(disp_done),
    .shown_value(shown_value), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, display;
    logic [1:0]  sel;
    logic [15:0] acc, rd, mem;
    logic        bf;
    logic [15:0] shown;
    logic        busy, done;
    logic [3:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[14];

  logic [6:0] hex7[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // behavioural model: ticks = edges elapsed while the display was scanning
  logic        m_wait, m_scan, m_done;
  logic [15:0] m_value;
  int unsigned m_ticks;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic d, input logic [1:0] s,
                       input logic [15:0] a, input logic [15:0] rg,
                       input logic [15:0] m, input logic b);
    rst_n = r; display = d; disp_sel = s;
    acc_data = a; reg_data = rg; mem_data = m; bool_flag = b;
  endtask

  task automatic model_edge();
    int unsigned nt;
    if (!rst_n) begin
      m_wait = 0; m_scan = 0; m_done = 0; m_value = '0; m_ticks = 0;
    end else begin
      nt = m_scan ? m_ticks + 1 : 0;
      m_done = 0;
      if (m_wait) begin
        m_value = mem_data; m_wait = 0; m_scan = 1; m_done = 1;
      end else if (display) begin
        if (disp_sel == 2'd2) m_wait = 1;
        else begin
          case (disp_sel)
            2'd0: m_value = acc_data;
            2'd1: m_value = reg_data;
            default: m_value = {15'b0, bool_flag};
          endcase
          m_scan = 1; m_done = 1;
        end
      end
      m_ticks = nt;
    end
  endtask

  task automatic model_check();
    int unsigned idx;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    idx = (m_ticks / DIV) % 4;
    exp_an  = m_scan ? ~(4'(1) << idx) : 4'hF;
    exp_seg = m_scan ? hex7[(m_value >> (4 * idx)) & 16'hF] : 7'h7F;
    chk("rnd_shown", shown_value, m_value);
    chk("rnd_busy", 16'(busy), 16'(m_wait));
    chk("rnd_done", 16'(disp_done), 16'(m_done));
    chk("rnd_an", 16'(an), 16'(exp_an));
    chk("rnd_seg", 16'(seg), 16'(exp_seg));
  endtask

  initial begin
    logic [3:0] scan_an[4];
    logic [6:0] scan_seg[4];

    vecs[0]  = '{0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4'hF, 7'h7F};
    vecs[1]  = '{1, 1, 2'd0, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 0, 1, 4'hE, 7'h0E};
    vecs[2]  = '{1, 0, 2'd0, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 0, 0, 4'hE, 7'h0E};
    vecs[3]  = '{1, 0, 2'd0, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 0, 0, 4'hE, 7'h0E};
    vecs[4]  = '{1, 0, 2'd0, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 0, 0, 4'hE, 7'h0E};
    vecs[5]  = '{1, 0, 2'd0, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 0, 0, 4'hD, 7'h30};
    vecs[6]  = '{1, 1, 2'd2, 16'h1A3F, 16'h0000, 16'h0000, 0, 16'h1A3F, 1, 0, 4'hD, 7'h30};
    vecs[7]  = '{1, 1, 2'd0, 16'h5555, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 0, 1, 4'hD, 7'h06};
    vecs[8]  = '{1, 0, 2'd0, 16'h5555, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 0, 0, 4'hD, 7'h06};
    vecs[9]  = '{1, 0, 2'd0, 16'h5555, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 0, 0, 4'hB, 7'h06};
    vecs[10] = '{1, 1, 2'd3, 16'h5555, 16'h0000, 16'hBEEF, 1, 16'h0001, 0, 1, 4'hB, 7'h40};
    vecs[11] = '{1, 1, 2'd2, 16'h5555, 16'h0000, 16'hBEEF, 1, 16'h0001, 1, 0, 4'hB, 7'h40};
    vecs[12] = '{0, 1, 2'd0, 16'hFFFF, 16'h0000, 16'hBEEF, 1, 16'h0000, 0, 0, 4'hF, 7'h7F};
    vecs[13] = '{1, 1, 2'd1, 16'hFFFF, 16'h1234, 16'h0000, 0, 16'h1234, 0, 1, 4'hE, 7'h19};

    drive(0, 0, 2'd0, '0, '0, '0, 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].display, vecs[i].sel, vecs[i].acc,
            vecs[i].rd, vecs[i].mem, vecs[i].bf);
      step();
      chk($sformatf("v%0d_shown", i), shown_value, vecs[i].shown);
      chk($sformatf("v%0d_busy", i), 16'(busy), 16'(vecs[i].busy));
      chk($sformatf("v%0d_done", i), 16'(disp_done), 16'(vecs[i].done));
      chk($sformatf("v%0d_an", i), 16'(an), 16'(vecs[i].an));
      chk($sformatf("v%0d_seg", i), 16'(seg), 16'(vecs[i].seg));
    end

    // full scan of 1A3F: each digit held for DIV cycles
    scan_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    scan_seg = '{7'h0E, 7'h30, 7'h08, 7'h79};
    drive(0, 0, 2'd0, '0, '0, '0, 0);
    step();
    drive(1, 1, 2'd0, 16'h1A3F, '0, '0, 0);
    step();
    display = 0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan%0d_an", k), 16'(an), 16'(scan_an[k / 4]));
      chk($sformatf("scan%0d_seg", k), 16'(seg), 16'(scan_seg[k / 4]));
      step();
    end

    // replacement in SHOW: index carries on, old value shown until capture
    drive(1, 1, 2'd0, 16'h1234, '0, '0, 0);
    step();
    chk("rep_first_seg", 16'(seg), 16'h19);
    display = 0;
    repeat (5) step();
    chk("rep_old_an", 16'(an), 16'hD);
    chk("rep_old_seg", 16'(seg), 16'h30);
    chk("rep_old_val", shown_value, 16'h1234);
    drive(1, 1, 2'd0, 16'h5678, '0, '0, 0);
    step();
    chk("rep_new_an", 16'(an), 16'hD);
    chk("rep_new_seg", 16'(seg), 16'h78);
    chk("rep_new_val", shown_value, 16'h5678);
    chk("rep_new_done", 16'(disp_done), 16'h1);

    // randomized traffic against the model
    drive(0, 0, 2'd0, '0, '0, '0, 0);
    model_edge();
    step();
    model_check();
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            16'($urandom), 1'($urandom));
      model_edge();
      step();
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
